control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Microcoded control unit for the 4-bit-address bus CPU. It generates the control word each cycle from a T-step counter, the instruction register opcode and the ALU flags. It is the initiator that drives the program counter's count, output and load enables, and the enables of MAR, RAM, IR, A, B, ALU, output register and flags.

Parameters:
OPCODE_W, 4, opcode width (IR upper nibble)
STEP_W, 3, T-step counter width
NUM_STEPS, 5, micro-steps per instruction (T0..T4); must be <= 2**STEP_W

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  OPCODE_W  IR opcode field; valid from T2 onward
carry_flag  input  1  registered ALU carry flag
zero_flag  input  1  registered ALU zero flag
pc_counter_enable  output  1  PC increments on the next edge
pc_output_enable  output  1  PC drives the bus
pc_input_enable  output  1  PC loads from the bus (jump)
ctrl  output  12  remaining control word (bit map in Behaviour)
halt  output  1  clock-stop request to the clock module
step  output  STEP_W  current T-step, for debug/display

Behaviour:
- Sync reset, active-high, clock clk. Reset: step=0, halted=0. Outputs decode to the T0 word: pc_output_enable=1, ctrl[0]=1, all else 0.
- ctrl bits: 0 mar_in, 1 ram_out, 2 ram_in, 3 ir_in, 4 ir_out, 5 a_in, 6 a_out, 7 b_in, 8 alu_out, 9 alu_sub, 10 out_in, 11 flags_in.
- Outputs are combinational from registered step, opcode and flags. No output is registered.
- Fetch, all opcodes: T0 pc_output_enable|mar_in; T1 ram_out|ir_in|pc_counter_enable.
- Execute, T2..T4. An unlisted step is the all-zero word.
  - 0000 NOP: none.
  - 0001 LDA: T2 ir_out|mar_in; T3 ram_out|a_in.
  - 0010 ADD: T2 ir_out|mar_in; T3 ram_out|b_in; T4 alu_out|a_in|flags_in.
  - 0011 SUB: same as ADD, plus alu_sub in T4 only.
  - 0100 STA: T2 ir_out|mar_in; T3 a_out|ram_in.
  - 0101 LDI: T2 ir_out|a_in.
  - 0110 JMP: T2 ir_out|pc_input_enable.
  - 0111 JC: T2 ir_out|pc_input_enable if carry_flag=1, else none.
  - 1000 JZ: as JC, using zero_flag.
  - 1110 OUT: T2 a_out|out_in.
  - 1111 HLT: T2 halt=1.
  - Any other opcode executes as NOP.
- Bus drivers (pc_output_enable, ram_out, ir_out, a_out, alu_out) are mutually exclusive in every step. pc_counter_enable and pc_input_enable are never both 1.
- Step advance: step increments each edge and wraps to 0 after step NUM_STEPS-1.
- HLT: at the edge ending T2, the sequencer enters HALTED.
  - In HALTED: halt=1, all other outputs 0, step frozen at 2.
  - HALTED is left only by reset.
- Reset during any step, including HALTED, wins. The next cycle is T0.
- Flags are sampled combinationally in T2 of JC/JZ. The bench holds them stable across that cycle.

Optional Feature:
Macro EARLY_STEP_RESET_EN.
- Defined: the step counter returns to 0 at the edge ending the last non-empty step of the instruction.
  - NOP ends after T1 (2 cycles).
  - LDI, JMP, JC, JZ, OUT end after T2 (3 cycles). JC/JZ take 3 cycles whether taken or not.
  - LDA, STA end after T3 (4 cycles).
  - ADD, SUB end after T4 (5 cycles).
- Undefined: every instruction takes NUM_STEPS cycles.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - ctrl bit index localparams and CTRL_W=12;
  - the 3 PC enable names.
- Sub-module microcode_decoder: purely combinational {step, opcode, flags} -> {pc enables, ctrl, halt, last_step}. The top holds the step register and HALTED state.

Test Plan:
- Reset for 2 cycles -> step=0, pc_output_enable=1, ctrl=12'h001, halt=0, pc_counter_enable=0.
- opcode=0001 (LDA) -> per cycle: T0 {PCO,MI}; T1 {RO,II,CE}; T2 {IO,MI}; T3 {RO,AI}. Then step=0 after 4 cycles with macro, after 5 without.
- ADD vs SUB -> T4 ctrl = 12'h920 for ADD and 12'hB20 for SUB. alu_sub=0 in T0..T3.
- JC: carry_flag=0 -> T2 all-zero word. carry_flag=1 -> T2 ir_out=1 and pc_input_enable=1. JZ: same with zero_flag.
- HLT -> halt=1 from T2 and held for 20 cycles. Step stays 2 and no other enable toggles. Reset then gives T0 with halt=0.
- Reset asserted in T3 of ADD -> next cycle step=0 and the T0 word. No b_in/a_in pulse follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, control-word bit map and PC enable bundle for the bus CPU control path.
package cpu_pkg;

    localparam int unsigned CTRL_W = 12;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned CTRL_MAR_IN   = 0;
    localparam int unsigned CTRL_RAM_OUT  = 1;
    localparam int unsigned CTRL_RAM_IN   = 2;
    localparam int unsigned CTRL_IR_IN    = 3;
    localparam int unsigned CTRL_IR_OUT   = 4;
    localparam int unsigned CTRL_A_IN     = 5;
    localparam int unsigned CTRL_A_OUT    = 6;
    localparam int unsigned CTRL_B_IN     = 7;
    localparam int unsigned CTRL_ALU_OUT  = 8;
    localparam int unsigned CTRL_ALU_SUB  = 9;
    localparam int unsigned CTRL_OUT_IN   = 10;
    localparam int unsigned CTRL_FLAGS_IN = 11;

    typedef struct packed {
        logic counter_en;
        logic output_en;
        logic input_en;
    } pc_en_t;

    typedef enum logic [0:0] {StRun, StHalted} seq_state_e;

endpackage

// File: rtl/microcode_decoder.sv
// Combinational microcode ROM: {step, opcode, flags} -> control word, halt and end-of-instruction.
// EARLY_STEP_RESET_EN shortens each instruction to its last non-empty step.
module microcode_decoder
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 4,
    parameter int unsigned STEP_W    = 3,
    parameter int unsigned NUM_STEPS = 5
) (
    input  logic [STEP_W-1:0]   step_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                carry_i,
    input  logic                zero_i,
    output pc_en_t              pc_en_o,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                halt_o,
    output logic                last_step_o
);

    localparam logic [STEP_W-1:0] T0    = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1    = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2    = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3    = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4    = STEP_W'(4);
    localparam logic [STEP_W-1:0] TLAST = STEP_W'(NUM_STEPS - 1);

    always_comb begin
        pc_en_o = '0;
        ctrl_o  = '0;
        halt_o  = 1'b0;
        case (step_i)
            T0: begin
                pc_en_o.output_en   = 1'b1;
                ctrl_o[CTRL_MAR_IN] = 1'b1;
            end
            T1: begin
                ctrl_o[CTRL_RAM_OUT] = 1'b1;
                ctrl_o[CTRL_IR_IN]   = 1'b1;
                pc_en_o.counter_en   = 1'b1;
            end
            T2: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_o[CTRL_IR_OUT] = 1'b1;
                        ctrl_o[CTRL_MAR_IN] = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_o[CTRL_IR_OUT] = 1'b1;
                        ctrl_o[CTRL_A_IN]   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_o[CTRL_IR_OUT] = 1'b1;
                        pc_en_o.input_en    = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_o[CTRL_IR_OUT] = carry_i;
                        pc_en_o.input_en    = carry_i;
                    end
                    OP_JZ: begin
                        ctrl_o[CTRL_IR_OUT] = zero_i;
                        pc_en_o.input_en    = zero_i;
                    end
                    OP_OUT: begin
                        ctrl_o[CTRL_A_OUT]  = 1'b1;
                        ctrl_o[CTRL_OUT_IN] = 1'b1;
                    end
                    OP_HLT:  halt_o = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (opcode_i)
                    OP_LDA: begin
                        ctrl_o[CTRL_RAM_OUT] = 1'b1;
                        ctrl_o[CTRL_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_o[CTRL_RAM_OUT] = 1'b1;
                        ctrl_o[CTRL_B_IN]    = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_o[CTRL_A_OUT]  = 1'b1;
                        ctrl_o[CTRL_RAM_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    ctrl_o[CTRL_ALU_OUT]  = 1'b1;
                    ctrl_o[CTRL_A_IN]     = 1'b1;
                    ctrl_o[CTRL_FLAGS_IN] = 1'b1;
                    ctrl_o[CTRL_ALU_SUB]  = (opcode_i == OP_SUB);
                end
            end
            default: ;
        endcase
    end

`ifdef EARLY_STEP_RESET_EN
    logic [STEP_W-1:0] last_idx;

    always_comb begin
        case (opcode_i)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_idx = T2;
            OP_LDA, OP_STA:                               last_idx = T3;
            OP_ADD, OP_SUB:                               last_idx = T4;
            default:                                      last_idx = T1;
        endcase
        // TLAST term keeps the counter bounded if the opcode changes mid-instruction
        last_step_o = (step_i == last_idx) || (step_i == TLAST);
    end
`else
    assign last_step_o = (step_i == TLAST);
`endif

endmodule

// File: rtl/control_sequencer.sv
// T-step counter and HALTED state around the microcode decoder; outputs are combinational.
// Optional EARLY_STEP_RESET_EN ends each instruction at its last non-empty step.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 4,
    parameter int unsigned STEP_W    = 3,
    parameter int unsigned NUM_STEPS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic                pc_counter_enable,
    output logic                pc_output_enable,
    output logic                pc_input_enable,
    output logic [CTRL_W-1:0]   ctrl,
    output logic                halt,
    output logic [STEP_W-1:0]   step
);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;

    pc_en_t            dec_pc_en;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_halt;
    logic              dec_last;

    microcode_decoder #(
        .OPCODE_W  (OPCODE_W),
        .STEP_W    (STEP_W),
        .NUM_STEPS (NUM_STEPS)
    ) u_decoder (
        .step_i      (step_q),
        .opcode_i    (opcode),
        .carry_i     (carry_flag),
        .zero_i      (zero_flag),
        .pc_en_o     (dec_pc_en),
        .ctrl_o      (dec_ctrl),
        .halt_o      (dec_halt),
        .last_step_o (dec_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        step_d            = step_q;
        pc_counter_enable = dec_pc_en.counter_en;
        pc_output_enable  = dec_pc_en.output_en;
        pc_input_enable   = dec_pc_en.input_en;
        ctrl              = dec_ctrl;
        halt              = dec_halt;
        unique case (state_q)
            StRun: begin
                if (dec_halt) begin
                    // step stays frozen at the HLT step while halted
                    state_d = StHalted;
                end else if (dec_last) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            StHalted: begin
                pc_counter_enable = 1'b0;
                pc_output_enable  = 1'b0;
                pc_input_enable   = 1'b0;
                ctrl              = '0;
                halt              = 1'b1;
            end
            default: state_d = StRun;
        endcase
    end

    assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random instruction streams
// checked against a table-driven model of the micro-program.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic        pc_counter_enable;
    logic        pc_output_enable;
    logic        pc_input_enable;
    logic [11:0] ctrl;
    logic        halt;
    logic [2:0]  step;

    int vectors = 0;
    int miscompares = 0;

    // Observed word layout: {halt, pc_in, pc_out, pc_count, ctrl[11:0]}
    localparam logic [15:0] MI  = 16'h0001;
    localparam logic [15:0] RO  = 16'h0002;
    localparam logic [15:0] RI  = 16'h0004;
    localparam logic [15:0] II  = 16'h0008;
    localparam logic [15:0] IO  = 16'h0010;
    localparam logic [15:0] AI  = 16'h0020;
    localparam logic [15:0] AO  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0080;
    localparam logic [15:0] EO  = 16'h0100;
    localparam logic [15:0] SU  = 16'h0200;
    localparam logic [15:0] OI  = 16'h0400;
    localparam logic [15:0] FI  = 16'h0800;
    localparam logic [15:0] CE  = 16'h1000;
    localparam logic [15:0] PCO = 16'h2000;
    localparam logic [15:0] PCI = 16'h4000;
    localparam logic [15:0] HL  = 16'h8000;

    control_sequencer u_dut (
        .clk               (clk),
        .reset             (reset),
        .opcode            (opcode),
        .carry_flag        (carry_flag),
        .zero_flag         (zero_flag),
        .pc_counter_enable (pc_counter_enable),
        .pc_output_enable  (pc_output_enable),
        .pc_input_enable   (pc_input_enable),
        .ctrl              (ctrl),
        .halt              (halt),
        .step              (step)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs_word();
        return {halt, pc_input_enable, pc_output_enable, pc_counter_enable, ctrl};
    endfunction

    function automatic int bus_drivers();
        return $countones({pc_output_enable, ctrl[1], ctrl[4], ctrl[6], ctrl[8]});
    endfunction

    // Micro-program as written in the instruction table.
    function automatic logic [15:0] model_word(int st, logic [3:0] op, logic c, logic z);
        logic [15:0] prog [5];
        prog = '{PCO | MI, RO | II | CE, 16'h0, 16'h0, 16'h0};
        case (op)
            4'h1: begin prog[2] = IO | MI; prog[3] = RO | AI; end
            4'h2: begin prog[2] = IO | MI; prog[3] = RO | BI; prog[4] = EO | AI | FI; end
            4'h3: begin prog[2] = IO | MI; prog[3] = RO | BI; prog[4] = EO | AI | FI | SU; end
            4'h4: begin prog[2] = IO | MI; prog[3] = AO | RI; end
            4'h5: prog[2] = IO | AI;
            4'h6: prog[2] = IO | PCI;
            4'h7: prog[2] = c ? (IO | PCI) : 16'h0;
            4'h8: prog[2] = z ? (IO | PCI) : 16'h0;
            4'hE: prog[2] = AO | OI;
            4'hF: prog[2] = HL;
            default: ;
        endcase
        return (st >= 0 && st < 5) ? prog[st] : 16'h0;
    endfunction

    function automatic int ilen(logic [3:0] op);
`ifdef EARLY_STEP_RESET_EN
        case (op)
            4'h1, 4'h4:                   return 4;
            4'h2, 4'h3:                   return 5;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE: return 3;
            default:                      return 2;
        endcase
`else
        return 5 + 0 * int'(op);
`endif
    endfunction

    // Runs one full instruction starting just after a negedge with the sequencer at T0.
    task automatic exec_instr(input logic [3:0] op, input logic c, input logic z);
        int n = ilen(op);
        for (int st = 0; st < n; st++) begin
            opcode = op; carry_flag = c; zero_flag = z;
            #1;
            vectors++;
            if (step !== 3'(st)) begin
                miscompares++;
                $display("FAIL step op=%h T%0d: got %0d want %0d", op, st, step, st);
            end
            vectors++;
            if (obs_word() !== model_word(st, op, c, z)) begin
                miscompares++;
                $display("FAIL word op=%h T%0d c=%0b z=%0b: got %h want %h",
                         op, st, c, z, obs_word(), model_word(st, op, c, z));
            end
            vectors++;
            if (bus_drivers() > 1 || (pc_counter_enable && pc_input_enable)) begin
                miscompares++;
                $display("FAIL exclusive op=%h T%0d: got word %h want <=1 driver", op, st,
                         obs_word());
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (step !== 3'd0) begin
            miscompares++;
            $display("FAIL wrap op=%h after %0d cycles: got step %0d want 0", op, n, step);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (step !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_step: got %0d want 0", step);
        end
        vectors++;
        if (obs_word() !== (PCO | MI)) begin
            miscompares++;
            $display("FAIL reset_word: got %h want %h", obs_word(), PCO | MI);
        end
        reset = 1'b0;
    endtask

    task automatic test_lda();
        exec_instr(4'h1, 1'b0, 1'b0);
    endtask

    task automatic test_add_sub();
        exec_instr(4'h2, 1'b0, 1'b0);
        exec_instr(4'h3, 1'b1, 1'b1);
    endtask

    task automatic test_jumps();
        exec_instr(4'h7, 1'b0, 1'b1);
        exec_instr(4'h7, 1'b1, 1'b0);
        exec_instr(4'h8, 1'b1, 1'b0);
        exec_instr(4'h8, 1'b0, 1'b1);
    endtask

    task automatic test_hlt();
        for (int st = 0; st < 3; st++) begin
            opcode = 4'hF;
            #1;
            vectors++;
            if (obs_word() !== model_word(st, 4'hF, 1'b0, 1'b0) || step !== 3'(st)) begin
                miscompares++;
                $display("FAIL hlt_fetch T%0d: got %h/%0d want %h/%0d", st, obs_word(), step,
                         model_word(st, 4'hF, 1'b0, 1'b0), st);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 20; i++) begin
            carry_flag = 1'($urandom_range(0, 1));
            zero_flag  = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (obs_word() !== HL || step !== 3'd2) begin
                miscompares++;
                $display("FAIL halted cycle %0d: got %h/%0d want %h/2", i, obs_word(), step, HL);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_word() !== (PCO | MI) || step !== 3'd0) begin
            miscompares++;
            $display("FAIL hlt_reset: got %h/%0d want %h/0", obs_word(), step, PCO | MI);
        end
    endtask

    task automatic test_reset_mid_add();
        for (int st = 0; st < 4; st++) begin
            opcode = 4'h2;
            #1;
            vectors++;
            if (obs_word() !== model_word(st, 4'h2, 1'b0, 1'b0)) begin
                miscompares++;
                $display("FAIL add_pre T%0d: got %h want %h", st, obs_word(),
                         model_word(st, 4'h2, 1'b0, 1'b0));
            end
            if (st == 3) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs_word() !== (PCO | MI) || step !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_reset_t0: got %h/%0d want %h/0", obs_word(), step, PCO | MI);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (obs_word() !== (RO | II | CE) || step !== 3'd1) begin
            miscompares++;
            $display("FAIL mid_reset_t1: got %h/%0d want %h/1", obs_word(), step, RO | II | CE);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 14));
            exec_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_add_sub();
        test_jumps();
        for (int op = 0; op < 15; op++) exec_instr(4'(op), 1'b1, 1'b0);
        test_reset_mid_add();
        test_random();
        test_hlt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
